// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between a load port and a store port sharing one data memory.
// Each granted request takes IDLE -> ACCESS -> RESP, or IDLE -> RESP when rejected.
module dmem_arbiter #(
  parameter bit CHECK_ALIGN = 1'b1,
  parameter bit STORE_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  output logic        ld_done,
  output logic        ld_err,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  dmem_inchoice,
  output logic [2:0]  dmem_outchoice,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_isStore;
  logic        r_lastStore;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_ldData;
  logic [2:0]  r_type;

  logic        w_grantAny;
  logic        w_grantStore;
  logic        w_ldBad;
  logic        w_stBad;
  logic        w_reqBad;
  logic [31:0] w_selAddr;
  logic [2:0]  w_selType;
  logic        w_access;
  logic        w_resp;

  // With both ports pending, the one not granted last wins.
  assign w_grantAny   = ld_req || st_req;
  assign w_grantStore = st_req && (!ld_req || !r_lastStore);
  assign w_selAddr    = w_grantStore ? st_addr : ld_addr;
  assign w_selType    = w_grantStore ? {1'b0, st_type} : ld_type;
  assign w_reqBad     = w_grantStore ? w_stBad : w_ldBad;

  always_comb begin
    w_ldBad = 1'b0;
    case (ld_type)
      3'b000:         w_ldBad = CHECK_ALIGN && (ld_addr[1:0] != 2'b00);
      3'b001, 3'b010: w_ldBad = CHECK_ALIGN && ld_addr[0];
      3'b011, 3'b100: w_ldBad = 1'b0;
      default:        w_ldBad = 1'b1;
    endcase
  end

  always_comb begin
    w_stBad = 1'b0;
    case (st_type)
      2'b01:   w_stBad = CHECK_ALIGN && (st_addr[1:0] != 2'b00);
      2'b10:   w_stBad = CHECK_ALIGN && st_addr[0];
      2'b11:   w_stBad = 1'b0;
      default: w_stBad = 1'b1;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grantAny) begin
          w_nextState = w_reqBad ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_isStore   <= 1'b0;
      r_lastStore <= !STORE_FIRST;
      r_err       <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_type      <= 3'b000;
      r_ldData    <= 32'h0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_IDLE && w_grantAny) begin
        r_isStore   <= w_grantStore;
        r_lastStore <= w_grantStore;
        r_err       <= w_reqBad;
        r_addr      <= w_selAddr;
        r_type      <= w_selType;
        r_wdata     <= st_data;
      end
      if (r_state == S_ACCESS && !r_isStore) begin
        r_ldData <= dmem_rdata;
      end
    end
  end

  // Memory controls are live only in ACCESS, so an async reset there also kills the write.
  assign w_access       = (r_state == S_ACCESS);
  assign w_resp         = (r_state == S_RESP);
  assign dmem_inchoice  = (w_access && r_isStore) ? r_type[1:0] : 2'b00;
  assign dmem_outchoice = (w_access && !r_isStore) ? r_type : 3'b111;
  assign dmem_addr      = w_access ? r_addr : 32'h0;
  assign dmem_wdata     = (w_access && r_isStore) ? r_wdata : 32'h0;

  assign ld_done = w_resp && !r_isStore;
  assign st_done = w_resp && r_isStore;
  assign ld_err  = ld_done && r_err;
  assign st_err  = st_done && r_err;
  assign ld_data = r_ldData;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-array memory model plus a scoreboard of
// expected completions (port, err, load data, completion cycle).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic        ld_done;
  logic        ld_err;
  logic [31:0] ld_data;
  logic        st_req;
  logic [31:0] st_addr;
  logic [1:0]  st_type;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_err;
  logic [1:0]  dmem_inchoice;
  logic [2:0]  dmem_outchoice;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        busy;

  typedef struct {
    bit          isStore;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cycleCnt = 0;
  logic [31:0] lastLd = 32'h0;
  logic [7:0]  mem [0:255];
  logic [7:0]  rdA;

  dmem_arbiter #(.CHECK_ALIGN(1'b1), .STORE_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type),
    .ld_done(ld_done), .ld_err(ld_err), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_type(st_type), .st_data(st_data),
    .st_done(st_done), .st_err(st_err),
    .dmem_inchoice(dmem_inchoice), .dmem_outchoice(dmem_outchoice),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Little-endian memory: combinational read with extension, write on negedge.
  always_comb begin
    rdA = dmem_addr[7:0];
    dmem_rdata = 32'h0;
    case (dmem_outchoice)
      3'b000: dmem_rdata = {mem[rdA + 8'd3], mem[rdA + 8'd2], mem[rdA + 8'd1], mem[rdA]};
      3'b001: dmem_rdata = {{16{mem[rdA + 8'd1][7]}}, mem[rdA + 8'd1], mem[rdA]};
      3'b010: dmem_rdata = {16'h0, mem[rdA + 8'd1], mem[rdA]};
      3'b011: dmem_rdata = {{24{mem[rdA][7]}}, mem[rdA]};
      3'b100: dmem_rdata = {24'h0, mem[rdA]};
      default: dmem_rdata = 32'h0;
    endcase
  end

  initial begin
    logic [7:0] wa;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      wa = dmem_addr[7:0];
      case (dmem_inchoice)
        2'b01: begin
          mem[wa] = dmem_wdata[7:0];
          mem[wa + 8'd1] = dmem_wdata[15:8];
          mem[wa + 8'd2] = dmem_wdata[23:16];
          mem[wa + 8'd3] = dmem_wdata[31:24];
        end
        2'b10: begin
          mem[wa] = dmem_wdata[7:0];
          mem[wa + 8'd1] = dmem_wdata[15:8];
        end
        2'b11: mem[wa] = dmem_wdata[7:0];
        default: ;
      endcase
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    checkEq({tag, "_ld_done"}, ld_done, 0);
    checkEq({tag, "_st_done"}, st_done, 0);
    checkEq({tag, "_ld_err"}, ld_err, 0);
    checkEq({tag, "_st_err"}, st_err, 0);
    checkEq({tag, "_busy"}, busy, 0);
    checkEq({tag, "_ld_data"}, ld_data, 32'h0);
    checkEq({tag, "_inchoice"}, dmem_inchoice, 2'b00);
    checkEq({tag, "_outchoice"}, dmem_outchoice, 3'b111);
    checkEq({tag, "_addr"}, dmem_addr, 32'h0);
    checkEq({tag, "_wdata"}, dmem_wdata, 32'h0);
  endtask

  task automatic pushExp(input bit isStore, input bit expErr, input logic [31:0] expData, input int cyc);
    exp_t e;
    e.isStore = isStore;
    e.err     = expErr;
    e.data    = (!isStore && !expErr) ? expData : lastLd;
    e.cyc     = cyc;
    if (!isStore && !expErr) lastLd = expData;
    sbq.push_back(e);
  endtask

  // Drives one request just after a posedge and records its expected completion.
  task automatic applyStimulus(input bit isStore, input logic [31:0] addr, input logic [2:0] typ,
                               input logic [31:0] data, input bit expErr,
                               input logic [31:0] expData, input int offset);
    @(posedge clk);
    #1;
    if (isStore) begin
      st_addr = addr;
      st_type = typ[1:0];
      st_data = data;
      st_req  = 1'b1;
    end else begin
      ld_addr = addr;
      ld_type = typ;
      ld_req  = 1'b1;
    end
    pushExp(isStore, expErr, expData, cycleCnt + offset);
  endtask

  task automatic checkOutput(input bit drop, input bit noAccess);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (noAccess) begin
        checkEq("noacc_inchoice", dmem_inchoice, 2'b00);
        checkEq("noacc_outchoice", dmem_outchoice, 3'b111);
      end
      if (ld_done || st_done) seen = 1'b1;
    end
    checkEq("done_seen", seen, 1);
    if (seen && sbq.size() > 0) begin
      e = sbq.pop_front();
      checkEq("done_port", st_done, e.isStore);
      checkEq("done_both", ld_done & st_done, 0);
      checkEq("done_err", e.isStore ? st_err : ld_err, e.err);
      if (!e.isStore) checkEq("ld_data", ld_data, e.data);
      checkEq("done_cycle", cycleCnt, e.cyc);
    end
    @(posedge clk);
    #1;
    if (drop) begin
      ld_req = 1'b0;
      st_req = 1'b0;
    end
    @(negedge clk);
    checkEq("done_pulse", {ld_done, st_done}, 0);
    checkEq("err_idle", {ld_err, st_err}, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    ld_addr = 32'h0; ld_type = 3'b000;
    st_addr = 32'h0; st_type = 2'b00; st_data = 32'h0;
    #12;
    checkReset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h10, 3'b001, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    @(posedge clk);
    #1;
    checkEq("st_acc_inchoice", dmem_inchoice, 2'b01);
    checkEq("st_acc_outchoice", dmem_outchoice, 3'b111);
    checkEq("st_acc_addr", dmem_addr, 32'h10);
    checkEq("st_acc_wdata", dmem_wdata, 32'hDEADBEEF);
    checkEq("st_acc_busy", busy, 1);
    checkOutput(1'b1, 1'b0);

    applyStimulus(1'b0, 32'h10, 3'b000, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    @(posedge clk);
    #1;
    checkEq("ld_acc_outchoice", dmem_outchoice, 3'b000);
    checkEq("ld_acc_inchoice", dmem_inchoice, 2'b00);
    checkEq("ld_acc_addr", dmem_addr, 32'h10);
    checkEq("ld_acc_wdata", dmem_wdata, 32'h0);
    checkOutput(1'b1, 1'b0);

    applyStimulus(1'b1, 32'h21, 3'b011, 32'hABCDEF80, 1'b0, 32'h0, 2);
    checkOutput(1'b1, 1'b0);
    applyStimulus(1'b0, 32'h21, 3'b011, 32'h0, 1'b0, 32'hFFFFFF80, 2);
    checkOutput(1'b1, 1'b0);
    applyStimulus(1'b0, 32'h21, 3'b100, 32'h0, 1'b0, 32'h00000080, 2);
    checkOutput(1'b1, 1'b0);
    applyStimulus(1'b0, 32'h20, 3'b001, 32'h0, 1'b0, 32'hFFFF8000, 2);
    checkOutput(1'b1, 1'b0);

    // Rejections: misaligned word load, illegal load type, illegal store type, misaligned half store.
    applyStimulus(1'b0, 32'h12, 3'b000, 32'h0, 1'b1, 32'h0, 1);
    checkOutput(1'b1, 1'b1);
    applyStimulus(1'b0, 32'h10, 3'b101, 32'h0, 1'b1, 32'h0, 1);
    checkOutput(1'b1, 1'b1);
    applyStimulus(1'b1, 32'h10, 3'b000, 32'h55555555, 1'b1, 32'h0, 1);
    checkOutput(1'b1, 1'b1);
    applyStimulus(1'b1, 32'h31, 3'b010, 32'h0000FFFF, 1'b1, 32'h0, 1);
    checkOutput(1'b1, 1'b1);

    applyStimulus(1'b1, 32'h30, 3'b001, 32'hCAFEF00D, 1'b0, 32'h0, 2);
    checkOutput(1'b1, 1'b0);

    // Store aborted by reset inside ACCESS, before the write negedge.
    @(posedge clk);
    #1;
    st_addr = 32'h30; st_type = 2'b01; st_data = 32'h12345678; st_req = 1'b1;
    @(posedge clk);
    #1;
    checkEq("abort_acc_inchoice", dmem_inchoice, 2'b01);
    rst_n = 1'b0;
    #1;
    checkReset("abort");
    st_req = 1'b0;
    lastLd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkEq("abort_no_done", st_done, 0);
    end
    #2;
    rst_n = 1'b1;

    // Both ports held after reset: load, store, load, store, three cycles apart.
    @(posedge clk);
    #1;
    ld_addr = 32'h40; ld_type = 3'b000;
    st_addr = 32'h40; st_type = 2'b01; st_data = 32'h11223344;
    base = cycleCnt;
    ld_req = 1'b1;
    st_req = 1'b1;
    pushExp(1'b0, 1'b0, 32'h0, base + 2);
    pushExp(1'b1, 1'b0, 32'h0, base + 5);
    pushExp(1'b0, 1'b0, 32'h11223344, base + 8);
    pushExp(1'b1, 1'b0, 32'h0, base + 11);
    checkOutput(1'b0, 1'b0);
    checkOutput(1'b0, 1'b0);
    checkOutput(1'b0, 1'b0);
    checkOutput(1'b1, 1'b0);

    applyStimulus(1'b0, 32'h30, 3'b000, 32'h0, 1'b0, 32'hCAFEF00D, 2);
    checkOutput(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
